// File: rtl/eyeriss_pkg.sv
// eyeriss_pkg: shared default widths, broadcast-tag helper and cast bus struct
package eyeriss_pkg;
  localparam int DEF_ROW_BITS = 4;
  localparam int DEF_COL_BITS = 4;
  localparam int DEF_DATA_W = 16;
  typedef struct packed {
    logic valid;
    logic [DEF_ROW_BITS-1:0] row;
    logic [DEF_COL_BITS-1:0] col;
    logic [DEF_DATA_W-1:0] data;
  } cast_t;
  function automatic logic [31:0] mc_bcast(input int width);
    return (width >= 32) ? '1 : (32'd1 << width) - 32'd1;
  endfunction
endpackage

// File: rtl/mc_fifo.sv
// mc_fifo: synchronous FIFO with wrap-bit pointers, flush and zeroed head when empty
module mc_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty = wr_q == rd_q;
    do_push = push & !full & !flush;
    do_pop = pop & !empty;
    wr_d = flush ? '0 : wr_q + {{AW{1'b0}}, do_push};
    rd_d = flush ? '0 : rd_q + {{AW{1'b0}}, do_pop};
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = data_i;
    count = wr_q - rd_q;
    head = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage needs no reset: the head is masked to zero whenever empty
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/multicast_node.sv
// multicast_node: tag-matching multicast receiver with scan-loaded ID and PE-side FIFO
module multicast_node import eyeriss_pkg::*; #(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     ctrl_enable,
  input  logic                     ctrl_flush,
  input  logic                     scan_en,
  input  logic                     scan_in,
  output logic                     scan_out,
  input  logic                     cast_valid_i,
  input  logic [ROW_BITS-1:0]      cast_row_i,
  input  logic [COL_BITS-1:0]      cast_col_i,
  input  logic [DATA_W-1:0]        cast_data_i,
  output logic                     cast_ready_o,
  output logic                     pe_valid_o,
  output logic [DATA_W-1:0]        pe_data_o,
  input  logic                     pe_ready_i,
  output logic [ROW_BITS-1:0]      row_id_o,
  output logic [COL_BITS-1:0]      col_id_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);
  localparam int ID_W = ROW_BITS + COL_BITS;
  logic [ID_W-1:0] id_q, id_d;
  logic row_ok, col_ok, hit, full, empty, push, pop;
  always_comb begin
    id_d = scan_en ? {id_q[ID_W-2:0], scan_in} : id_q;
    row_id_o = id_q[ID_W-1 -: ROW_BITS];
    col_id_o = id_q[COL_BITS-1:0];
    scan_out = id_q[ID_W-1];
    row_ok = (cast_row_i == row_id_o) | (cast_row_i == ROW_BITS'(mc_bcast(ROW_BITS)));
    col_ok = (cast_col_i == col_id_o) | (cast_col_i == COL_BITS'(mc_bcast(COL_BITS)));
    hit = ctrl_enable & !scan_en & row_ok & col_ok;
    // ready deliberately ignores cast_valid_i so non-targeted nodes never stall the bus
    cast_ready_o = !hit | !full;
    push = cast_valid_i & hit & !full;
    pe_valid_o = !empty;
    pop = pe_valid_o & pe_ready_i;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) id_q <= '0;
    else id_q <= id_d;
  end
  mc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .nrst(nrst),
    .push(push),
    .pop(pop),
    .flush(ctrl_flush),
    .data_i(cast_data_i),
    .full(full),
    .empty(empty),
    .count(occupancy_o),
    .head(pe_data_o)
  );
endmodule

// File: doc/multicast_node.md
# multicast_node

Parametrised multicast receiver for one PE on the global input network. It matches a `{row, col}` tag on the shared cast bus against a scan-loaded node ID, with per-field broadcast wildcards. Matching words are buffered in a small FIFO and delivered to the PE over a valid/ready handshake. It sits between the GIN X/Y bus and each PE's input port, one instance per PE per data type (ifmap, filter, psum).

## Interface
Parameters:
- `ROW_BITS`, default 4: width of the row ID field.
- `COL_BITS`, default 4: width of the column ID field.
- `DATA_W`, default 16: payload width.
- `DEPTH`, default 4: FIFO depth; must be a power of two and ≥ 2.

Ports:
- `clk`, in, 1: single clock; everything is rising-edge.
- `nrst`, in, 1: reset, asynchronous and active-low.
- `ctrl_enable`, in, 1: when low, the node accepts no new words.
- `ctrl_flush`, in, 1: synchronous FIFO clear.
- `scan_en`, in, 1: shift the ID register.
- `scan_in`, in, 1: serial ID input.
- `scan_out`, out, 1: MSB of the ID register, for chaining.
- `cast_valid_i`, in, 1: bus word valid.
- `cast_row_i`, in, `ROW_BITS`: destination row tag.
- `cast_col_i`, in, `COL_BITS`: destination column tag.
- `cast_data_i`, in, `DATA_W`: payload.
- `cast_ready_o`, out, 1: node can take the current word.
- `pe_valid_o`, out, 1: FIFO not empty.
- `pe_data_o`, out, `DATA_W`: FIFO head.
- `pe_ready_i`, in, 1: PE consumes the head.
- `row_id_o`, out, `ROW_BITS`: current row ID.
- `col_id_o`, out, `COL_BITS`: current column ID.
- `occupancy_o`, out, `$clog2(DEPTH)+1`: number of words held.

## Operation
- **ID register:** `{row_id, col_id}`, `ID_W = ROW_BITS + COL_BITS` bits.
  - When `scan_en` is high: shift left one bit per cycle, LSB ← `scan_in`. The ID is therefore loaded MSB-first over `ID_W` cycles.
  - `scan_out` is the register MSB, taken directly from the flop.
- **Match:** `hit = ctrl_enable & !scan_en & row_ok & col_ok`.
  - `row_ok = (cast_row_i == row_id) | (cast_row_i == all-ones)`.
  - `col_ok` is defined the same way on the column fields.
  - The all-ones value is reserved as the broadcast wildcard and must never be loaded as a node ID.
- **Ready:** `cast_ready_o = !hit | !full`. This is combinational from tag/state and independent of `cast_valid_i`. A non-targeted node never stalls the bus.
- **Push:** `cast_valid_i & hit & !full`.
- **Pop:** `pe_valid_o & pe_ready_i`.
- **Output:** `pe_valid_o = !empty`. `pe_data_o` is the head word when not empty, and 0 when empty.
- **Flush:** `ctrl_flush` empties the FIFO on the next edge. It takes priority over a same-cycle push and pop; storage contents are don't-care.
- **Disable:** `ctrl_enable` low blocks pushes only. The FIFO continues draining to the PE.

## Timing
- **Reset values:**
  - ID = 0, so `row_id_o = 0`, `col_id_o = 0`, `scan_out = 0`.
  - FIFO empty, so `pe_valid_o = 0`, `pe_data_o = 0`, `occupancy_o = 0`.
  - `cast_ready_o` follows the combinational rule above.
- **Latency:** a word accepted at edge N appears on `pe_valid_o`/`pe_data_o` after edge N; there is no combinational bus-to-PE path.
- **Throughput:** one push and one pop per cycle.
  - Simultaneous push and pop while non-empty and non-full: occupancy unchanged.
  - When full, push is blocked even if the PE pops in the same cycle (no pass-through). The bus sees `cast_ready_o = 0` for that cycle.
- **Pointers:** `$clog2(DEPTH)+1` bits, wrap naturally. `full` = MSBs differ and lower bits equal; `empty` = pointers equal.
- **`scan_en` during traffic:** `hit` is forced low, so the bus word is not taken by this node while `cast_ready_o = 1`. The upstream controller must not cast during scan.
- **Reset mid-operation:** asynchronous clear of the ID, pointers and output; no partial shift is retained.

## Structure
- Shared package `eyeriss_pkg`:
  - default `ROW_BITS`/`COL_BITS`/`DATA_W` localparams;
  - the `mc_bcast(width)` all-ones helper;
  - a `cast_t` struct for the default widths, for top-level wiring.
- Sub-module `mc_fifo`: a synchronous FIFO with parameters `DATA_W` and `DEPTH`, ports push/pop/flush, full/empty, count and head. Match logic and the scan register stay in `multicast_node`.

## Test plan
- **Scan and unicast:** scan in row=2, col=5 (ID 0x25, 8 cycles, MSB-first), check `row_id_o = 2` and `col_id_o = 5`. Cast tag (2,5) data 0xABCD → `pe_valid_o` and `pe_data_o = 0xABCD` one cycle later. Cast tag (2,6) → ignored, `cast_ready_o = 1`.
- **Wildcards:** with ID (2,5), casts (0xF,5), (2,0xF) and (0xF,0xF) are each accepted; cast (0xF,4) is dropped.
- **Full:** with `pe_ready_i = 0`, push 4 matching words → `occupancy_o = 4` and `cast_ready_o` low for a matching tag but high for a non-matching tag. Raise `pe_ready_i` → words come out in FIFO order, and the fifth is accepted only after the first pop.
- **Concurrent and flush:** steady push+pop for 16 cycles → occupancy constant and ordering preserved. Assert `ctrl_flush` with a concurrent push → next cycle `occupancy_o = 0` and `pe_valid_o = 0`.
- **Enable and reset:** with `ctrl_enable = 0`, a matching cast is not accepted but the existing 2 words drain. Assert `nrst` mid-scan and with 3 words queued → ID 0, all outputs at reset values immediately.
